fifo_stream_reader: RTL and testbench

Read-side drain engine for the team's FIFO. It pops words from the FIFO read port (rd/r_data/empty) and presents them downstream on a registered valid/ready stream. A 2-entry output buffer gives one word per cycle under continuous ready and fully absorbs downstream back-pressure. It also keeps a running count of words delivered downstream.

---
 rtl/fifo_stream_reader.sv | 83 ++++++++
 tb/tb_fifo_stream_reader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a show-ahead FIFO into a registered valid/ready
// stream through a 2-entry in-order buffer (slot0 = head, slot1 = skid), and
// counts the words accepted downstream.
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              rd_o,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              busy_o
);

    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_slot0;
    logic [DATA_W-1:0] r_slot1;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_pop;
    logic              w_acc;

    // Pop only when there is room; deliberately independent of m_ready_i so the
    // FIFO side never sees a combinational path from downstream.
    assign w_pop = en_i & ~empty_i & (r_occ < 2'd2) & ~flush_i & rst_ni;
    assign w_acc = m_valid_o & m_ready_i;

    assign rd_o      = w_pop;
    assign m_valid_o = (r_occ != 2'd0);
    assign busy_o    = (r_occ != 2'd0);
    assign m_data_o  = r_slot0;
    assign cnt_o     = r_cnt;

    // Occupancy: flush empties the buffer, otherwise occ + pop - accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ <= 2'd0;
        end else if (flush_i) begin
            r_occ <= 2'd0;
        end else begin
            r_occ <= r_occ + {1'b0, w_pop} - {1'b0, w_acc};
        end
    end

    // Buffer slots: accept shifts skid into head; a pop lands at the tail that
    // remains after any same-cycle accept, so ordering is preserved.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (!flush_i) begin
            if (w_acc) begin
                if (r_occ == 2'd2) begin
                    r_slot0 <= r_slot1;
                end else if (w_pop) begin
                    r_slot0 <= r_data_i;
                end
            end else if (w_pop) begin
                if (r_occ == 2'd0) begin
                    r_slot0 <= r_data_i;
                end else begin
                    r_slot1 <= r_data_i;
                end
            end
        end
    end

    // Delivered-word counter; accepts during a flush still count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO and buffer model, a
// per-cycle compare process, and directed scenarios plus a random phase.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, flush = 1'b0, empty = 1'b1;
  logic          ready = 1'b0, rd, valid, busy;
  logic [DW-1:0] rdata = '0, mdata;
  logic [CW-1:0] cnt;

  int checks = 0, errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] mb_q[$];
  logic [DW-1:0] dlv_q[$];
  logic [DW-1:0] exp_q[$];
  int exp_cnt = 0, cyc = 0, npops = 0, first_pop = 0, last_pop = 0;
  int p_ready = 100, p_en = 100, p_flush = 0;
  bit alt = 1'b0;

  fifo_stream_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush), .empty_i(empty),
    .r_data_i(rdata), .rd_o(rd), .m_valid_o(valid), .m_data_o(mdata),
    .m_ready_i(ready), .cnt_o(cnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    empty = (fifo_q.size() == 0);
    rdata = empty ? '0 : fifo_q[0];
  endtask

  // Behavioural model of one clock edge, using pre-edge inputs.
  task automatic model_edge();
    bit acc, pop;
    cyc++;
    if (!rst_n) return;
    acc = (mb_q.size() != 0) && ready;
    pop = en && (fifo_q.size() != 0) && (mb_q.size() < 2) && !flush;
    if (acc) begin
      exp_cnt++;
      dlv_q.push_back(mb_q[0]);
    end
    if (flush) mb_q.delete();
    else begin
      if (acc) void'(mb_q.pop_front());
      if (pop) mb_q.push_back(fifo_q[0]);
    end
    if (pop) begin
      void'(fifo_q.pop_front());
      npops++;
      if (npops == 1) first_pop = cyc;
      last_pop = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    ready = alt ? ~ready : ($urandom_range(0, 99) < p_ready);
    en    = ($urandom_range(0, 99) < p_en);
    flush = ($urandom_range(0, 99) < p_flush);
    drive_fifo();
  endtask

  task automatic drain(string nm);
    int n = 0;
    while ((fifo_q.size() != 0 || mb_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk({nm, "_drain_left"}, fifo_q.size() + mb_q.size(), 0);
  endtask

  task automatic chk_dlv(string nm);
    chk({nm, "_count"}, dlv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dlv_q.size(); i++)
      chk({nm, "_word"}, dlv_q[i], exp_q[i]);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rd_o", rd, 0);
      chk("rst_m_valid_o", valid, 0);
      chk("rst_m_data_o", mdata, 0);
      chk("rst_cnt_o", cnt, 0);
      chk("rst_busy_o", busy, 0);
    end else begin
      chk("rd_o", rd, en && !empty && (mb_q.size() < 2) && !flush);
      chk("m_valid_o", valid, mb_q.size() != 0);
      chk("busy_o", busy, mb_q.size() != 0);
      chk("cnt_o", cnt, exp_cnt % (1 << CW));
      if (mb_q.size() != 0) chk("m_data_o", mdata, mb_q[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with empty FIFO and enable high
    en = 1'b1;
    drive_fifo();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // 2: four words, continuous ready
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(i * 10));
    drive_fifo();
    dlv_q.delete(); exp_q.delete(); npops = 0;
    drain("t2");
    step();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i * 10));
    chk_dlv("t2");
    chk("t2_pops", npops, 4);
    chk("t2_pop_span", last_pop - first_pop, 3);
    chk("t2_cnt", cnt, 4);
    chk("t2_valid_after", valid, 0);

    // 3: back-pressure fills the buffer, then release
    p_ready = 0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(40 + i * 10));
    drive_fifo();
    dlv_q.delete(); exp_q.delete(); npops = 0;
    repeat (5) step();
    chk("t3_pops", npops, 2);
    chk("t3_fifo_left", fifo_q.size(), 3);
    chk("t3_rd", rd, 0);
    chk("t3_valid", valid, 1);
    chk("t3_data_held", mdata, 40);
    chk("t3_busy", busy, 1);
    p_ready = 100;
    drain("t3");
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(40 + i * 10));
    chk_dlv("t3");

    // 4: alternating ready, eight words
    dlv_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      fifo_q.push_back(exp_q[i]);
    end
    drive_fifo();
    alt = 1'b1;
    drain("t4");
    alt = 1'b0;
    step();
    chk_dlv("t4");
    chk("t4_cnt_wrap", cnt, 1);  // 4 + 5 + 8 = 17 words, 4-bit counter

    // 5: flush with two buffered words
    p_ready = 0;
    fifo_q.push_back(8'd1); fifo_q.push_back(8'd2); fifo_q.push_back(8'd3);
    drive_fifo();
    repeat (4) step();
    chk("t5_fifo_left", fifo_q.size(), 1);
    flush = 1'b1;
    step();
    chk("t5_valid_after_flush", valid, 0);
    chk("t5_cnt_after_flush", cnt, 1);
    p_ready = 100;
    dlv_q.delete(); exp_q.delete();
    exp_q.push_back(8'd3);
    drain("t5");
    chk_dlv("t5");

    // random phase
    p_en = 80; p_ready = 60; p_flush = 5;
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 3) begin
        fifo_q.push_back(8'($urandom_range(0, 255)));
        drive_fifo();
      end
      step();
    end
    p_en = 100; p_ready = 100; p_flush = 0;
    drain("rand");

    // 6: asynchronous reset mid-stream
    p_ready = 0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'(100 + i));
    drive_fifo();
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd", rd, 0);
    chk("t6_valid", valid, 0);
    chk("t6_data", mdata, 0);
    chk("t6_cnt", cnt, 0);
    chk("t6_busy", busy, 0);
    mb_q.delete();
    exp_cnt = 0;
    repeat (2) step();
    rst_n = 1'b1;
    p_ready = 100;
    dlv_q.delete(); exp_q.delete();
    for (int i = 2; i < 5; i++) exp_q.push_back(8'(100 + i));
    drain("t6");
    step();
    chk_dlv("t6");
    chk("t6_cnt_after", cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
